// File: rtl/freq_step_ctrl.sv
// freq_step_ctrl
//   Pushbutton front end for the throttle datapath. Two raw buttons are
//   synchronised and debounced, then an FSM turns debounced presses into
//   single steps plus auto-repeat on hold. The resulting saturating setting
//   freq_num selects the period of the slow_tick enable and slow_clk.

module freq_step_ctrl #(
    parameter int unsigned DEB_CYCLES   = 500000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter int unsigned FREQ_W       = 4,
    parameter int unsigned FREQ_MAX     = 15,
    parameter int unsigned FREQ_INIT    = 8,
    parameter int unsigned BASE_DIV     = 50000
) (
    input  logic              CLK_50,
    input  logic              reset,
    input  logic              pb_freq_up,
    input  logic              pb_freq_dn,
    output logic [FREQ_W-1:0] freq_num,
    output logic              slow_tick,
    output logic              slow_clk,
    output logic              at_max,
    output logic              at_min
);

    localparam int unsigned DEB_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);
    localparam int unsigned DIV_W   = $clog2(BASE_DIV * (FREQ_MAX + 1) + 1);

    localparam int unsigned BTN_UP = 0;
    localparam int unsigned BTN_DN = 1;

    typedef enum logic [1:0] {
        IDLE,
        UP_HOLD,
        DN_HOLD,
        BOTH
    } state_t;

    // Button vectors: bit 0 = up, bit 1 = down
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [DEB_W-1:0] deb_cnt [2];

    state_t           state;
    state_t           state_nxt;
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_limit;
    logic             rpt_first;
    logic             rpt_clr;
    logic             rpt_fire;
    logic             step_up;
    logic             step_dn;
    logic             btn_u;
    logic             btn_d;

    logic [FREQ_W-1:0] freq_nxt;
    logic              freq_chg;
    logic [DIV_W-1:0]  period;
    logic [DIV_W-1:0]  div_cnt;

    assign btn_u = deb[BTN_UP];
    assign btn_d = deb[BTN_DN];

    // Two-flop synchroniser for both raw buttons
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {pb_freq_dn, pb_freq_up};
            sync2 <= sync1;
        end
    end

    // Debounce: level follows the synced input only after DEB_CYCLES
    // consecutive cycles of disagreement; any agreement restarts the count
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            deb <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_W'(DEB_CYCLES - 1)) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
                end
            end
        end
    end

    // FSM state register
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and step decisions; release of the own button is
    // checked before the repeat timer so a final repeat never fires late
    always_comb begin
        state_nxt = state;
        step_up   = 1'b0;
        step_dn   = 1'b0;
        rpt_clr   = 1'b0;
        rpt_fire  = 1'b0;
        rpt_limit = rpt_first ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_RATE - 1);
        case (state)
            IDLE: begin
                if (btn_u && btn_d) begin
                    state_nxt = BOTH;
                end else if (btn_u) begin
                    step_up   = 1'b1;
                    rpt_clr   = 1'b1;
                    state_nxt = UP_HOLD;
                end else if (btn_d) begin
                    step_dn   = 1'b1;
                    rpt_clr   = 1'b1;
                    state_nxt = DN_HOLD;
                end
            end
            UP_HOLD: begin
                if (btn_d) begin
                    state_nxt = BOTH;
                end else if (!btn_u) begin
                    state_nxt = IDLE;
                end else if (rpt_cnt == rpt_limit) begin
                    step_up  = 1'b1;
                    rpt_fire = 1'b1;
                end
            end
            DN_HOLD: begin
                if (btn_u) begin
                    state_nxt = BOTH;
                end else if (!btn_d) begin
                    state_nxt = IDLE;
                end else if (rpt_cnt == rpt_limit) begin
                    step_dn  = 1'b1;
                    rpt_fire = 1'b1;
                end
            end
            BOTH: begin
                if (!btn_u && !btn_d) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Auto-repeat timer: first interval REPEAT_DELAY, then REPEAT_RATE
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (rpt_clr) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else if (state == UP_HOLD || state == DN_HOLD) begin
            rpt_cnt <= rpt_cnt + RPT_W'(1);
        end
    end

    // Saturating next value of the frequency setting
    always_comb begin
        freq_nxt = freq_num;
        if (step_up && freq_num != FREQ_W'(FREQ_MAX)) begin
            freq_nxt = freq_num + FREQ_W'(1);
        end else if (step_dn && freq_num != '0) begin
            freq_nxt = freq_num - FREQ_W'(1);
        end
    end

    assign freq_chg = (freq_nxt != freq_num);

    // Frequency setting register
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            freq_num <= FREQ_W'(FREQ_INIT);
        end else begin
            freq_num <= freq_nxt;
        end
    end

    // Tick period for the current setting
    always_comb begin
        period = DIV_W'(BASE_DIV * (FREQ_MAX + 1 - 32'(freq_num)));
    end

    // A pending change suppresses the tick so a new period always starts
    // cleanly from zero on the cycle the new setting appears
    assign slow_tick = (freq_num != '0) && !freq_chg && (div_cnt == period - DIV_W'(1));

    // Divider counter; held at zero while the setting is zero
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (freq_chg || freq_num == '0 || slow_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // slow_clk toggles on every tick, giving a 50% duty square wave
    always_ff @(posedge CLK_50 or negedge reset) begin
        if (!reset) begin
            slow_clk <= 1'b0;
        end else if (slow_tick) begin
            slow_clk <= ~slow_clk;
        end
    end

    assign at_max = (freq_num == FREQ_W'(FREQ_MAX));
    assign at_min = (freq_num == '0);

endmodule

// File: tb/tb_freq_step_ctrl.sv
// tb_freq_step_ctrl
//   Directed stimulus with hand-computed expectations. Expected freq_num
//   changes and slow_tick cycles are queued by the stimulus; a monitor on the
//   falling edge pops and compares whenever the DUT presents one.

module tb_freq_step_ctrl;

    logic       CLK_50 = 1'b0;
    logic       reset  = 1'b0;
    logic       pb_up  = 1'b0;
    logic       pb_dn  = 1'b0;
    logic [2:0] freq_num;
    logic       slow_tick;
    logic       slow_clk;
    logic       at_max;
    logic       at_min;

    freq_step_ctrl #(
        .DEB_CYCLES  (4),
        .REPEAT_DELAY(20),
        .REPEAT_RATE (8),
        .FREQ_W      (3),
        .FREQ_MAX    (7),
        .FREQ_INIT   (4),
        .BASE_DIV    (2)
    ) dut (
        .CLK_50    (CLK_50),
        .reset     (reset),
        .pb_freq_up(pb_up),
        .pb_freq_dn(pb_dn),
        .freq_num  (freq_num),
        .slow_tick (slow_tick),
        .slow_clk  (slow_clk),
        .at_max    (at_max),
        .at_min    (at_min)
    );

    always #5 CLK_50 = ~CLK_50;

    int cyc = 0;
    always @(posedge CLK_50) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int val;
    } ev_t;

    ev_t  freq_q[$];
    int   tick_q[$];
    bit   tick_watch = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name, input int act, input int exp);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_freq(input int c, input int v);
        ev_t e;
        e.cyc = c;
        e.val = v;
        freq_q.push_back(e);
    endtask

    task automatic close_ticks();
        while (tick_q.size() > 0) flag("tick_missing_at_cycle", -1, tick_q.pop_front());
        tick_watch = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge CLK_50);
    endtask

    // Monitor: freq_num changes are always scored; ticks only while watched
    logic [2:0] prev_freq = 3'd4;
    ev_t        mev;
    always @(negedge CLK_50) begin
        if (reset) begin
            while (freq_q.size() > 0 && freq_q[0].cyc < cyc) begin
                mev = freq_q.pop_front();
                flag("freq_missing_at_cycle", int'(freq_num), mev.cyc);
            end
            if (freq_num != prev_freq) begin
                if (freq_q.size() == 0) begin
                    flag("freq_unexpected_change", int'(freq_num), int'(prev_freq));
                end else begin
                    mev = freq_q.pop_front();
                    check("freq_value", int'(freq_num), mev.val);
                    check("freq_cycle", cyc, mev.cyc);
                end
            end
            if (tick_watch) begin
                while (tick_q.size() > 0 && tick_q[0] < cyc) flag("tick_missing_at_cycle", -1, tick_q.pop_front());
                if (slow_tick) begin
                    if (tick_q.size() == 0) flag("tick_unexpected", cyc, -1);
                    else check("tick_cycle", cyc, tick_q.pop_front());
                end
            end
        end
        prev_freq = freq_num;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int r;
        logic s;

        // Reset state
        repeat (3) @(negedge CLK_50);
        check("rst_freq", int'(freq_num), 4);
        check("rst_tick", int'(slow_tick), 0);
        check("rst_sclk", int'(slow_clk), 0);
        check("rst_at_max", int'(at_max), 0);
        check("rst_at_min", int'(at_min), 0);

        // 1: idle, period 8, slow_clk period 16
        #2 reset = 1'b1;
        c = cyc;
        for (int i = 0; i < 4; i++) tick_q.push_back(c + 7 + 8 * i);
        tick_watch = 1'b1;
        wait_cyc(c + 8);
        check("sclk_high", int'(slow_clk), 1);
        wait_cyc(c + 16);
        check("sclk_low", int'(slow_clk), 0);
        wait_cyc(c + 34);
        close_ticks();

        // 2: short pulse rejected, held press steps once at +7, period 6
        wait_cyc(c + 40);
        c = cyc;
        pb_up = 1'b1;
        wait_cyc(c + 3);
        pb_up = 1'b0;
        wait_cyc(c + 15);
        c = cyc;
        push_freq(c + 7, 5);
        tick_q.push_back(c + 12);
        tick_q.push_back(c + 18);
        tick_q.push_back(c + 24);
        pb_up = 1'b1;
        wait_cyc(c + 7);
        tick_watch = 1'b1;
        wait_cyc(c + 8);
        check("freq_after_up", int'(freq_num), 5);
        wait_cyc(c + 10);
        pb_up = 1'b0;
        wait_cyc(c + 26);
        close_ticks();

        // back to 4 with a single down press
        wait_cyc(c + 40);
        c = cyc;
        push_freq(c + 7, 4);
        pb_dn = 1'b1;
        wait_cyc(c + 10);
        pb_dn = 1'b0;
        wait_cyc(c + 30);

        // 3: hold up 60 cycles -> 5,6,7 at +7,+27,+35, saturates
        c = cyc;
        push_freq(c + 7, 5);
        push_freq(c + 27, 6);
        push_freq(c + 35, 7);
        pb_up = 1'b1;
        wait_cyc(c + 30);
        check("at_max_before", int'(at_max), 0);
        wait_cyc(c + 40);
        check("at_max_sat", int'(at_max), 1);
        wait_cyc(c + 60);
        pb_up = 1'b0;
        wait_cyc(c + 80);
        check("freq_sat_hold", int'(freq_num), 7);
        check("at_min_at_top", int'(at_min), 0);

        // 4: both pressed, up released, dn held: no steps until both released
        c = cyc;
        pb_up = 1'b1;
        pb_dn = 1'b1;
        wait_cyc(c + 10);
        pb_up = 1'b0;
        wait_cyc(c + 40);
        pb_dn = 1'b0;
        wait_cyc(c + 60);
        check("both_no_step", int'(freq_num), 7);
        c = cyc;
        push_freq(c + 7, 6);
        pb_dn = 1'b1;
        wait_cyc(c + 10);
        pb_dn = 1'b0;
        wait_cyc(c + 30);

        // 5: hold down to 0, ticks stop, then one up press resumes period 14
        c = cyc;
        push_freq(c + 7, 5);
        push_freq(c + 27, 4);
        push_freq(c + 35, 3);
        push_freq(c + 43, 2);
        push_freq(c + 51, 1);
        push_freq(c + 59, 0);
        pb_dn = 1'b1;
        wait_cyc(c + 60);
        check("at_min_zero", int'(at_min), 1);
        tick_watch = 1'b1;
        s = slow_clk;
        wait_cyc(c + 70);
        pb_dn = 1'b0;
        wait_cyc(c + 100);
        check("sclk_frozen", int'(slow_clk), int'(s));
        c = cyc;
        push_freq(c + 7, 1);
        tick_q.push_back(c + 20);
        tick_q.push_back(c + 34);
        pb_up = 1'b1;
        wait_cyc(c + 10);
        pb_up = 1'b0;
        wait_cyc(c + 25);
        check("sclk_resumed", int'(slow_clk), int'(!s));
        wait_cyc(c + 40);
        close_ticks();
        check("at_min_left", int'(at_min), 0);

        // 6: async reset during auto-repeat with up still held
        c = cyc;
        push_freq(c + 7, 2);
        push_freq(c + 27, 3);
        pb_up = 1'b1;
        wait_cyc(c + 30);
        #2 reset = 1'b0;
        #1;
        check("async_rst_freq", int'(freq_num), 4);
        check("async_rst_sclk", int'(slow_clk), 0);
        check("async_rst_tick", int'(slow_tick), 0);
        wait_cyc(c + 33);
        #2 reset = 1'b1;
        r = cyc;
        push_freq(r + 7, 5);
        push_freq(r + 27, 6);
        push_freq(r + 35, 7);
        wait_cyc(r + 38);
        pb_up = 1'b0;
        wait_cyc(r + 60);
        check("final_freq", int'(freq_num), 7);

        while (freq_q.size() > 0) begin
            ev_t e;
            e = freq_q.pop_front();
            flag("freq_never_seen_at_cycle", -1, e.cyc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
